// File: rtl/hex_word_sender_if.sv
// Word-in / character-out handshake bundle for hex_word_sender.
// The master modport is the converter's view; slave is the surrounding logic.
interface hex_word_sender_if #(
    parameter int WORD_WIDTH = 32
) ();
    // Both handshakes use strict valid/ready semantics. A transfer happens on
    // any rising edge where valid and ready are both high. Once the sender
    // raises valid, it holds valid and data stable until that transfer.
    logic                  word_valid;
    logic                  word_ready;
    logic [WORD_WIDTH-1:0] word_data;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;

    modport master (
        input  word_valid, word_data, tx_ready,
        output word_ready, tx_data, tx_valid, busy
    );

    modport slave (
        output word_valid, word_data, tx_ready,
        input  word_ready, tx_data, tx_valid, busy
    );
endinterface

// File: rtl/hex_word_sender.sv
// Prints a binary word as lowercase ASCII hex, MSB nibble first, with an
// optional CR/LF trailer, one registered character per tx handshake.
module hex_word_sender #(
    parameter int WORD_WIDTH     = 32,
    parameter bit APPEND_NEWLINE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    hex_word_sender_if.master  bus,
    output logic [1:0]         dbg_state
);
    localparam int N  = WORD_WIDTH / 4;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        CR    = 2'd2,
        LF    = 2'd3
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] shifted;
    logic [CW-1:0]         cnt;
    logic                  tx_fire;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // shreg always holds the digit on tx_data in its top nibble, so the next
    // digit to present is the top nibble of the shifted value.
    assign shifted   = shreg << 4;
    assign tx_fire   = bus.tx_valid & bus.tx_ready;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            bus.tx_data    <= 8'h00;
            bus.tx_valid   <= 1'b0;
            bus.word_ready <= 1'b1;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.word_valid && bus.word_ready) begin
                        shreg          <= bus.word_data;
                        cnt            <= CW'(N);
                        bus.tx_data    <= hex_ascii(bus.word_data[WORD_WIDTH-1 -: 4]);
                        bus.tx_valid   <= 1'b1;
                        bus.word_ready <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= DIGIT;
                    end
                end

                DIGIT: begin
                    if (tx_fire) begin
                        shreg <= shifted;
                        cnt   <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            if (APPEND_NEWLINE) begin
                                bus.tx_data <= 8'h0D;
                                state       <= CR;
                            end else begin
                                bus.tx_valid   <= 1'b0;
                                bus.word_ready <= 1'b1;
                                bus.busy       <= 1'b0;
                                state          <= IDLE;
                            end
                        end else begin
                            bus.tx_data <= hex_ascii(shifted[WORD_WIDTH-1 -: 4]);
                        end
                    end
                end

                CR: begin
                    if (tx_fire) begin
                        bus.tx_data <= 8'h0A;
                        state       <= LF;
                    end
                end

                LF: begin
                    // tx_data keeps 0x0A while idle; only valid drops.
                    if (tx_fire) begin
                        bus.tx_valid   <= 1'b0;
                        bus.word_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
